// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes and
// controller state encoding.
package mdu_pkg;

  localparam int MDU_OP_W = 3;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers. One result bit per
// cycle on unsigned magnitudes, then a single cycle that applies the signs.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(WIDTH);

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      return ~v + ONE_W;
    end else begin
      return v;
    end
  endfunction

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               op_signed_s, op_div_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH:0]   div_shift_s;
  logic [WIDTH:0]     div_top_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_rem_s;
  logic [2*WIDTH-1:0] iter_acc_s;
  logic [2*WIDTH-1:0] neg_prod_s;
  logic [WIDTH-1:0]   fix_hi_s, fix_lo_s;

  assign op_signed_s = (op == MDU_MULT) || (op == MDU_DIV);
  assign op_div_s    = (op == MDU_DIV)  || (op == MDU_DIVU);

  // Multiply keeps the multiplier in the low half and shifts the partial sum in from the top.
  assign mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                       (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
  assign div_shift_s = {acc_q, 1'b0};
  assign div_top_s   = div_shift_s[2*WIDTH:WIDTH];
  assign div_ge_s    = (div_top_s >= {1'b0, opb_q});
  assign div_rem_s   = div_top_s[WIDTH-1:0] - opb_q;
  assign iter_acc_s  = is_div_q ?
                       (div_ge_s ? {div_rem_s, div_shift_s[WIDTH-1:1], 1'b1}
                                 : div_shift_s[2*WIDTH-1:0])
                       : {mul_sum_s, acc_q[WIDTH-1:1]};

  assign neg_prod_s  = ~acc_q + ONE_2W;
  assign fix_hi_s    = !is_div_q ? (neg_q ? neg_prod_s[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH])
                     : div0_q    ? dvd_q
                     : neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + ONE_W) : acc_q[2*WIDTH-1:WIDTH];
  assign fix_lo_s    = !is_div_q ? (neg_q ? neg_prod_s[WIDTH-1:0] : acc_q[WIDTH-1:0])
                     : div0_q    ? ONES_W
                     : neg_q     ? (~acc_q[WIDTH-1:0] + ONE_W) : acc_q[WIDTH-1:0];

  // Next-state logic: accept in IDLE, one step per cycle in ITER, sign fix-up and write in FIX.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    dvd_d     = dvd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          case (op)
            MDU_MTHI: hi_d = a;
            MDU_MTLO: lo_d = a;
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              is_div_d  = op_div_s;
              neg_d     = op_signed_s && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_rem_d = op_signed_s && a[WIDTH-1];
              div0_d    = op_div_s && (b == ZERO_W);
              dvd_d     = a;
              if (op_div_s) begin
                acc_d = {ZERO_W, magnitude(a, op_signed_s)};
                opb_d = magnitude(b, op_signed_s);
              end else begin
                acc_d = {ZERO_W, magnitude(b, op_signed_s)};
                opb_d = magnitude(a, op_signed_s);
              end
              cnt_d   = CNT_INIT;
              state_d = ITER;
            end
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      ITER: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          acc_d = iter_acc_s;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = FIX;
          end else begin
            state_d = ITER;
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        if (cancel) begin
          done_d = 1'b0;
        end else begin
          hi_d   = fix_hi_s;
          lo_d   = fix_lo_s;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      acc_q     <= {2*WIDTH{1'b0}};
      opb_q     <= ZERO_W;
      dvd_q     <= ZERO_W;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= ZERO_W;
      lo_q      <= ZERO_W;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      dvd_q     <= dvd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed test-plan vectors plus randomized
// back-to-back traffic checked against an arithmetic reference model.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst, start, cancel;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int done_seen = 0;

  mdu_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // count done pulses mid-cycle
  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(output int nbusy, output int lat);
    nbusy = 0; lat = -1;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) begin lat = i; break; end
      if (busy === 1'b1) nbusy++;
      tick();
    end
  endtask

  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el);
    longint sx, sy, sq, sr;
    logic [63:0] p;
    logic [31:0] uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    eh = 32'd0; el = 32'd0;
    case (o)
      MDU_MULT:  begin p = 64'(sx * sy); eh = p[63:32]; el = p[31:0]; end
      MDU_MULTU: begin p = {32'd0, x} * {32'd0, y}; eh = p[63:32]; el = p[31:0]; end
      MDU_DIV: begin
        if (y == 32'd0) begin eh = x; el = 32'hFFFFFFFF; end
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin eh = 32'd0; el = 32'h80000000; end
        else begin sq = sx / sy; sr = sx % sy; el = sq[31:0]; eh = sr[31:0]; end
      end
      MDU_DIVU: begin
        if (y == 32'd0) begin eh = x; el = 32'hFFFFFFFF; end
        else begin uq = x / y; ur = x % y; el = uq; eh = ur; end
      end
      default: begin eh = 32'd0; el = 32'd0; end
    endcase
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h00000000;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; cancel = 1'b1; op = MDU_MTHI; a = 32'hFFFFFFFF; b = 32'd0;
    repeat (3) tick();
    total_cnt++;
    if ({busy, done, hi, lo} !== {1'b0, 1'b0, 32'd0, 32'd0})
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, required 0/0/0/0", busy, done, hi, lo);
    else pass_cnt++;
    rst = 1'b0; start = 1'b0; cancel = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] x, y, eh, el;
  } vec_t;

  task automatic test_directed();
    vec_t v[7];
    int nb, lat, d0;
    v[0] = '{MDU_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    v[1] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    v[2] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    v[3] = '{MDU_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF};
    v[4] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    v[5] = '{MDU_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    v[6] = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    foreach (v[i]) begin
      issue(v[i].o, v[i].x, v[i].y);
      d0 = done_seen;
      wait_done(nb, lat);
      total_cnt++;
      if (lat != LAT || nb != LAT)
        $display("FAIL directed%0d_latency: done after %0d busy %0d, required %0d/%0d", i, lat, nb, LAT, LAT);
      else pass_cnt++;
      total_cnt++;
      if (hi !== v[i].eh || lo !== v[i].el)
        $display("FAIL directed%0d_result: hi=%h lo=%h, required hi=%h lo=%h", i, hi, lo, v[i].eh, v[i].el);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (done !== 1'b0 || done_seen - d0 != 1)
        $display("FAIL directed%0d_pulse: done=%b pulses=%0d, required 0/1", i, done, done_seen - d0);
      else pass_cnt++;
    end
  endtask

  task automatic test_mthi_mtlo();
    int d0;
    d0 = done_seen;
    issue(MDU_MTHI, 32'h12345678, 32'd0);
    total_cnt++;
    if (hi !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL mthi: hi=%h busy=%b done=%b, required 12345678/0/0", hi, busy, done);
    else pass_cnt++;
    issue(MDU_MTLO, 32'h9ABCDEF0, 32'd0);
    total_cnt++;
    if (lo !== 32'h9ABCDEF0 || hi !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL mtlo: hi=%h lo=%h busy=%b done=%b, required 12345678/9abcdef0/0/0", hi, lo, busy, done);
    else pass_cnt++;
    issue(3'd6, 32'hDEADBEEF, 32'd1);
    issue(3'd7, 32'hDEADBEEF, 32'd1);
    tick();
    total_cnt++;
    if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0 || busy !== 1'b0 || done_seen != d0)
      $display("FAIL illegal_op: hi=%h lo=%h busy=%b pulses=%0d, required unchanged/0/0", hi, lo, busy, done_seen - d0);
    else pass_cnt++;
  endtask

  task automatic test_start_while_busy();
    int nb, lat, d0;
    issue(MDU_MULT, 32'd6, 32'd7);
    d0 = done_seen;
    repeat (9) tick();
    start = 1'b1; op = MDU_DIVU; a = 32'd9; b = 32'd3;
    tick();
    start = 1'b0;
    wait_done(nb, lat);
    total_cnt++;
    if (lat < 0 || lo !== 32'd42 || hi !== 32'd0)
      $display("FAIL busy_start_result: lat=%0d hi=%h lo=%h, required hi=0 lo=2a", lat, hi, lo);
    else pass_cnt++;
    repeat (3) tick();
    total_cnt++;
    if (done_seen - d0 != 1 || busy !== 1'b0)
      $display("FAIL busy_start_pulses: pulses=%0d busy=%b, required 1/0", done_seen - d0, busy);
    else pass_cnt++;
  endtask

  task automatic test_cancel();
    int d0;
    issue(MDU_MTHI, 32'hCAFEF00D, 32'd0);
    issue(MDU_MTLO, 32'h0BADBEEF, 32'd0);
    d0 = done_seen;
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (4) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL cancel_iter_busy: busy=%b, required 0", busy);
    else pass_cnt++;
    repeat (40) tick();
    total_cnt++;
    if (done_seen != d0 || hi !== 32'hCAFEF00D || lo !== 32'h0BADBEEF)
      $display("FAIL cancel_iter_regs: pulses=%0d hi=%h lo=%h, required 0/cafef00d/0badbeef", done_seen - d0, hi, lo);
    else pass_cnt++;
    issue(MDU_DIVU, 32'd1000, 32'd3);
    repeat (W) tick();
    total_cnt++;
    if (busy !== 1'b1)
      $display("FAIL cancel_fix_busy_before: busy=%b, required 1", busy);
    else pass_cnt++;
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    tick();
    total_cnt++;
    if (busy !== 1'b0 || done_seen != d0 || hi !== 32'hCAFEF00D || lo !== 32'h0BADBEEF)
      $display("FAIL cancel_fix: busy=%b pulses=%0d hi=%h lo=%h, required 0/0/cafef00d/0badbeef", busy, done_seen - d0, hi, lo);
    else pass_cnt++;
    start = 1'b1; cancel = 1'b1; op = MDU_MTHI; a = 32'h11111111;
    tick();
    op = MDU_MULT;
    tick();
    start = 1'b0; cancel = 1'b0;
    total_cnt++;
    if (hi !== 32'hCAFEF00D || busy !== 1'b0)
      $display("FAIL cancel_idle: hi=%h busy=%b, required cafef00d/0", hi, busy);
    else pass_cnt++;
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++;
    if ({busy, done, hi, lo} !== {1'b0, 1'b0, 32'd0, 32'd0})
      $display("FAIL reset_midop: busy=%b done=%b hi=%h lo=%h, required 0/0/0/0", busy, done, hi, lo);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x, y, eh, el, hm, lm;
    int nb, lat;
    issue(MDU_MTHI, 32'd0, 32'd0);
    issue(MDU_MTLO, 32'd0, 32'd0);
    hm = 32'd0; lm = 32'd0;
    for (int n = 0; n < 48; n++) begin
      o = 3'($urandom_range(0, 7)); x = pick(); y = pick();
      issue(o, x, y);
      if (o <= 3'd3) begin
        model(o, x, y, eh, el);
        wait_done(nb, lat);
        total_cnt++;
        if (lat != LAT || hi !== eh || lo !== el)
          $display("FAIL random%0d op=%0d a=%h b=%h: lat=%0d hi=%h lo=%h, required lat=%0d hi=%h lo=%h",
                   n, o, x, y, lat, hi, lo, LAT, eh, el);
        else pass_cnt++;
        hm = eh; lm = el;
      end else begin
        if (o == MDU_MTHI) hm = x;
        else if (o == MDU_MTLO) lm = x;
        total_cnt++;
        if (hi !== hm || lo !== lm || busy !== 1'b0)
          $display("FAIL random%0d op=%0d: hi=%h lo=%h busy=%b, required hi=%h lo=%h busy=0",
                   n, o, hi, lo, busy, hm, lm);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    test_reset();
    test_directed();
    test_mthi_mtlo();
    test_start_while_busy();
    test_cancel();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
